unidade_controle: RTL

Moore control FSM that sequences one game of the PoliLobinho werewolf round and drives every control input of `fluxo_dados`. It sits directly upstream of the datapath and consumes its status flags (`CJ_fim`, `jogador_vivo`). Its phases are:
- seed capture
- per-player class reveal
- night actions for living players only
- elimination evaluation
- day/wait loop

---
 rtl/unidade_controle.sv | 117 +++++++++++
 1 files changed

// File: rtl/unidade_controle.sv
// Moore control FSM for one PoliLobinho round: seed capture, class reveal,
// night actions for living players, elimination and the day/wait loop.
module unidade_controle (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       confirmar,
    input  logic       CJ_fim,
    input  logic       jogador_vivo,
    output logic       rst_global,
    output logic       zera_CS,
    output logic       zera_CJ,
    output logic       inc_seed,
    output logic       e_seed_reg,
    output logic       inc_jogador,
    output logic       mostra_classe,
    output logic       processar_acao,
    output logic       avaliar_eliminacao,
    output logic       noite_fim,
    output logic [3:0] db_estado
);

    typedef enum logic [3:0] {
        INICIAL        = 4'd0,
        ESPERA         = 4'd1,
        TRAVA_SEED     = 4'd2,
        CARREGA_SEED   = 4'd3,
        PREPARA_REVELA = 4'd4,
        REVELA         = 4'd5,
        PROX_REVELA    = 4'd6,
        INICIO_NOITE   = 4'd7,
        VERIFICA_VIVO  = 4'd8,
        ACAO           = 4'd9,
        REGISTRA       = 4'd10,
        PROX_NOITE     = 4'd11,
        ELIMINA        = 4'd12,
        DIA            = 4'd13
    } estado_t;

    estado_t estado_q, estado_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q <= INICIAL;
        end else begin
            estado_q <= estado_d;
        end
    end

    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            INICIAL:        estado_d = ESPERA;
            ESPERA:         if (iniciar) estado_d = TRAVA_SEED;
            // TRAVA_SEED gives the synchronous seed ROM one cycle on a frozen address
            TRAVA_SEED:     estado_d = CARREGA_SEED;
            CARREGA_SEED:   estado_d = PREPARA_REVELA;
            PREPARA_REVELA: estado_d = REVELA;
            REVELA: begin
                if (confirmar) estado_d = CJ_fim ? INICIO_NOITE : PROX_REVELA;
            end
            PROX_REVELA:    estado_d = PREPARA_REVELA;
            INICIO_NOITE:   estado_d = VERIFICA_VIVO;
            VERIFICA_VIVO: begin
                if (jogador_vivo)  estado_d = ACAO;
                else if (CJ_fim)   estado_d = ELIMINA;
                else               estado_d = PROX_NOITE;
            end
            ACAO:           if (confirmar) estado_d = REGISTRA;
            REGISTRA:       estado_d = CJ_fim ? ELIMINA : PROX_NOITE;
            PROX_NOITE:     estado_d = VERIFICA_VIVO;
            ELIMINA:        estado_d = DIA;
            DIA: begin
                if (iniciar)        estado_d = INICIAL;
                else if (confirmar) estado_d = INICIO_NOITE;
            end
            default:        estado_d = INICIAL;
        endcase
    end

    always_comb begin
        rst_global         = 1'b0;
        zera_CS            = 1'b0;
        zera_CJ            = 1'b0;
        inc_seed           = 1'b0;
        e_seed_reg         = 1'b0;
        inc_jogador        = 1'b0;
        mostra_classe      = 1'b0;
        processar_acao     = 1'b0;
        avaliar_eliminacao = 1'b0;
        noite_fim          = 1'b0;
        case (estado_q)
            INICIAL: begin
                rst_global = 1'b1;
                zera_CS    = 1'b1;
                zera_CJ    = 1'b1;
            end
            ESPERA:       inc_seed = 1'b1;
            CARREGA_SEED: begin
                e_seed_reg = 1'b1;
                zera_CJ    = 1'b1;
            end
            REVELA:       mostra_classe      = 1'b1;
            PROX_REVELA:  inc_jogador        = 1'b1;
            INICIO_NOITE: zera_CJ            = 1'b1;
            ACAO:         mostra_classe      = 1'b1;
            REGISTRA:     processar_acao     = 1'b1;
            PROX_NOITE:   inc_jogador        = 1'b1;
            ELIMINA:      avaliar_eliminacao = 1'b1;
            DIA:          noite_fim          = 1'b1;
            default: ;
        endcase
    end

    assign db_estado = estado_q;

endmodule
